// File: rtl/datapath_register_bank.sv
// AR/PC/DR/AC/IR/TR register bank with shared common bus and memory interface.
// Registers update one edge after their strobe; bus and memory outputs are combinational; no backpressure.
module datapath_register_bank #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_AR,
  input  logic              load_PC,
  input  logic              load_DR,
  input  logic              load_AC,
  input  logic              load_IR,
  input  logic              load_TR,
  input  logic              clear_AR,
  input  logic              clear_PC,
  input  logic              clear_DR,
  input  logic              clear_AC,
  input  logic              clear_TR,
  input  logic              inc_AR,
  input  logic              inc_PC,
  input  logic              inc_DR,
  input  logic              inc_AC,
  input  logic              inc_TR,
  input  logic              memory_read,
  input  logic              memory_write,
  input  logic [2:0]        bus_selectors,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic [DATA_W-1:0] IR,
  output logic [DATA_W-1:0] ac_out,
  output logic [DATA_W-1:0] dr_out,
  output logic [DATA_W-1:0] pc_out,
  output logic [DATA_W-1:0] bus_out,
  output logic              zero_flag,
  output logic              bus_error
);

  localparam logic [2:0] SEL_ZERO = 3'b000;
  localparam logic [2:0] SEL_AR   = 3'b001;
  localparam logic [2:0] SEL_PC   = 3'b010;
  localparam logic [2:0] SEL_DR   = 3'b011;
  localparam logic [2:0] SEL_AC   = 3'b100;
  localparam logic [2:0] SEL_OPND = 3'b101;
  localparam logic [2:0] SEL_TR   = 3'b110;
  localparam logic [2:0] SEL_MEM  = 3'b111;

  localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] ar;
  logic [DATA_W-1:0] pc;
  logic [DATA_W-1:0] dr;
  logic [DATA_W-1:0] ac;
  logic [DATA_W-1:0] tr;

  logic [DATA_W-1:0] bus;
  logic [DATA_W-1:0] ar_next;
  logic [DATA_W-1:0] pc_next;
  logic [DATA_W-1:0] dr_next;
  logic [DATA_W-1:0] ac_next;
  logic [DATA_W-1:0] tr_next;
  logic              ac_change;
  logic              illegal_write;

  // Priority clear > load > inc; increment wraps modulo 2^DATA_W.
  function automatic logic [DATA_W-1:0] next_val(
    input logic              clr,
    input logic              ld,
    input logic              inc,
    input logic [DATA_W-1:0] cur,
    input logic [DATA_W-1:0] src
  );
    logic [DATA_W-1:0] r;
    if (clr)      r = '0;
    else if (ld)  r = src;
    else if (inc) r = cur + ONE;
    else          r = cur;
    return r;
  endfunction

  always_comb begin
    bus = '0;
    case (bus_selectors)
      SEL_ZERO: bus = '0;
      SEL_AR:   bus = ar;
      SEL_PC:   bus = pc;
      SEL_DR:   bus = dr;
      SEL_AC:   bus = ac;
      SEL_OPND: bus = {{(DATA_W-4){1'b0}}, IR[3:0]};
      SEL_TR:   bus = tr;
      SEL_MEM:  bus = memory_read ? mem_rdata : '0;
      default:  bus = '0;
    endcase
  end

  always_comb begin
    ar_next   = next_val(clear_AR, load_AR, inc_AR, ar, bus);
    pc_next   = next_val(clear_PC, load_PC, inc_PC, pc, bus);
    dr_next   = next_val(clear_DR, load_DR, inc_DR, dr, bus);
    ac_next   = next_val(clear_AC, load_AC, inc_AC, ac, alu_result);
    tr_next   = next_val(clear_TR, load_TR, inc_TR, tr, bus);
    ac_change = clear_AC | load_AC | inc_AC;
  end

  // A memory-to-memory write has no defined source, so it is dropped and flagged.
  assign illegal_write = memory_write && (bus_selectors == SEL_MEM);
  assign mem_we        = memory_write && (bus_selectors != SEL_MEM);
  assign mem_addr      = ar[ADDR_W-1:0];
  assign mem_wdata     = bus;
  assign bus_out       = bus;
  assign ac_out        = ac;
  assign dr_out        = dr;
  assign pc_out        = pc;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ar        <= '0;
      pc        <= '0;
      dr        <= '0;
      ac        <= '0;
      IR        <= '0;
      tr        <= '0;
      zero_flag <= 1'b1;
      bus_error <= 1'b0;
    end else begin
      ar <= ar_next;
      pc <= pc_next;
      dr <= dr_next;
      ac <= ac_next;
      tr <= tr_next;
      if (load_IR) IR <= bus;
      if (ac_change) zero_flag <= (ac_next == '0);
      if (illegal_write) bus_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_datapath_register_bank.sv
// Directed table-driven bench for datapath_register_bank plus reset / sticky-error sequences.
module tb_datapath_register_bank;

  logic       clk;
  logic       reset;
  logic       load_AR, load_PC, load_DR, load_AC, load_IR, load_TR;
  logic       clear_AR, clear_PC, clear_DR, clear_AC, clear_TR;
  logic       inc_AR, inc_PC, inc_DR, inc_AC, inc_TR;
  logic       memory_read, memory_write;
  logic [2:0] bus_selectors;
  logic [7:0] alu_result, mem_rdata;
  logic [7:0] mem_addr, mem_wdata, IR, ac_out, dr_out, pc_out, bus_out;
  logic       mem_we, zero_flag, bus_error;

  int total = 0;
  int bad   = 0;

  datapath_register_bank #(.DATA_W(8), .ADDR_W(8)) dut (
    .clock(clk), .reset(reset),
    .load_AR(load_AR), .load_PC(load_PC), .load_DR(load_DR),
    .load_AC(load_AC), .load_IR(load_IR), .load_TR(load_TR),
    .clear_AR(clear_AR), .clear_PC(clear_PC), .clear_DR(clear_DR),
    .clear_AC(clear_AC), .clear_TR(clear_TR),
    .inc_AR(inc_AR), .inc_PC(inc_PC), .inc_DR(inc_DR), .inc_AC(inc_AC), .inc_TR(inc_TR),
    .memory_read(memory_read), .memory_write(memory_write),
    .bus_selectors(bus_selectors), .alu_result(alu_result), .mem_rdata(mem_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .IR(IR),
    .ac_out(ac_out), .dr_out(dr_out), .pc_out(pc_out), .bus_out(bus_out),
    .zero_flag(zero_flag), .bus_error(bus_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ld = {AR,PC,DR,AC,IR,TR}; clr/inc = {AR,PC,DR,AC,TR}
  typedef struct {
    logic [5:0] ld;
    logic [4:0] clr;
    logic [4:0] inc;
    logic       rd;
    logic       wr;
    logic [2:0] sel;
    logic [7:0] alu;
    logic [7:0] rdata;
    logic [7:0] e_bus;
    logic       e_we;
    logic [7:0] e_ar, e_pc, e_dr, e_ac, e_ir;
    logic       e_zf, e_be;
  } vec_t;

  localparam int NV = 23;
  vec_t tbl [NV];

  task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic idle();
    {load_AR, load_PC, load_DR, load_AC, load_IR, load_TR} = '0;
    {clear_AR, clear_PC, clear_DR, clear_AC, clear_TR} = '0;
    {inc_AR, inc_PC, inc_DR, inc_AC, inc_TR} = '0;
    memory_read = 1'b0; memory_write = 1'b0;
    bus_selectors = 3'b000; alu_result = 8'h00; mem_rdata = 8'h00;
  endtask

  task automatic drive(input vec_t v);
    {load_AR, load_PC, load_DR, load_AC, load_IR, load_TR} = v.ld;
    {clear_AR, clear_PC, clear_DR, clear_AC, clear_TR} = v.clr;
    {inc_AR, inc_PC, inc_DR, inc_AC, inc_TR} = v.inc;
    memory_read = v.rd; memory_write = v.wr;
    bus_selectors = v.sel; alu_result = v.alu; mem_rdata = v.rdata;
  endtask

  logic [7:0] prev_ar;

  initial begin
    //         ld          clr       inc       rd    wr    sel     alu    rdata  bus    we    ar     pc     dr     ac     ir     zf    be
    tbl[0]  = '{6'b000100, 5'b00000, 5'b00000, 1'b0, 1'b0, 3'b000, 8'h03, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 1'b0, 1'b0};
    tbl[1]  = '{6'b010000, 5'b00000, 5'b00000, 1'b0, 1'b0, 3'b100, 8'h00, 8'h00, 8'h03, 1'b0, 8'h00, 8'h03, 8'h00, 8'h03, 8'h00, 1'b0, 1'b0};
    tbl[2]  = '{6'b100000, 5'b00000, 5'b00000, 1'b0, 1'b0, 3'b010, 8'h00, 8'h00, 8'h03, 1'b0, 8'h03, 8'h03, 8'h00, 8'h03, 8'h00, 1'b0, 1'b0};
    tbl[3]  = '{6'b000010, 5'b00000, 5'b01000, 1'b1, 1'b0, 3'b111, 8'h00, 8'hA6, 8'hA6, 1'b0, 8'h03, 8'h04, 8'h00, 8'h03, 8'hA6, 1'b0, 1'b0};
    tbl[4]  = '{6'b100000, 5'b00000, 5'b00000, 1'b0, 1'b0, 3'b101, 8'h00, 8'h00, 8'h06, 1'b0, 8'h06, 8'h04, 8'h00, 8'h03, 8'hA6, 1'b0, 1'b0};
    tbl[5]  = '{6'b000000, 5'b10000, 5'b10000, 1'b0, 1'b0, 3'b000, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 8'h04, 8'h00, 8'h03, 8'hA6, 1'b0, 1'b0};
    tbl[6]  = '{6'b100000, 5'b00000, 5'b01000, 1'b0, 1'b0, 3'b010, 8'h00, 8'h00, 8'h04, 1'b0, 8'h04, 8'h05, 8'h00, 8'h03, 8'hA6, 1'b0, 1'b0};
    tbl[7]  = '{6'b010000, 5'b00000, 5'b01000, 1'b0, 1'b0, 3'b001, 8'h00, 8'h00, 8'h04, 1'b0, 8'h04, 8'h04, 8'h00, 8'h03, 8'hA6, 1'b0, 1'b0};
    tbl[8]  = '{6'b000001, 5'b00000, 5'b00000, 1'b0, 1'b0, 3'b010, 8'h00, 8'h00, 8'h04, 1'b0, 8'h04, 8'h04, 8'h00, 8'h03, 8'hA6, 1'b0, 1'b0};
    tbl[9]  = '{6'b001000, 5'b00000, 5'b00001, 1'b0, 1'b0, 3'b110, 8'h00, 8'h00, 8'h04, 1'b0, 8'h04, 8'h04, 8'h04, 8'h03, 8'hA6, 1'b0, 1'b0};
    tbl[10] = '{6'b000000, 5'b00001, 5'b00100, 1'b0, 1'b0, 3'b110, 8'h00, 8'h00, 8'h05, 1'b0, 8'h04, 8'h04, 8'h05, 8'h03, 8'hA6, 1'b0, 1'b0};
    tbl[11] = '{6'b001000, 5'b00100, 5'b00100, 1'b0, 1'b0, 3'b110, 8'h00, 8'h00, 8'h00, 1'b0, 8'h04, 8'h04, 8'h00, 8'h03, 8'hA6, 1'b0, 1'b0};
    tbl[12] = '{6'b000100, 5'b00000, 5'b00000, 1'b0, 1'b0, 3'b000, 8'hFF, 8'h00, 8'h00, 1'b0, 8'h04, 8'h04, 8'h00, 8'hFF, 8'hA6, 1'b0, 1'b0};
    tbl[13] = '{6'b000000, 5'b00000, 5'b00010, 1'b0, 1'b0, 3'b000, 8'h00, 8'h00, 8'h00, 1'b0, 8'h04, 8'h04, 8'h00, 8'h00, 8'hA6, 1'b1, 1'b0};
    tbl[14] = '{6'b000100, 5'b00000, 5'b00000, 1'b0, 1'b0, 3'b000, 8'h10, 8'h00, 8'h00, 1'b0, 8'h04, 8'h04, 8'h00, 8'h10, 8'hA6, 1'b0, 1'b0};
    tbl[15] = '{6'b000000, 5'b00000, 5'b00000, 1'b0, 1'b0, 3'b000, 8'h00, 8'h00, 8'h00, 1'b0, 8'h04, 8'h04, 8'h00, 8'h10, 8'hA6, 1'b0, 1'b0};
    tbl[16] = '{6'b000100, 5'b00010, 5'b00000, 1'b0, 1'b0, 3'b000, 8'h77, 8'h00, 8'h00, 1'b0, 8'h04, 8'h04, 8'h00, 8'h00, 8'hA6, 1'b1, 1'b0};
    tbl[17] = '{6'b000000, 5'b00000, 5'b00010, 1'b0, 1'b0, 3'b000, 8'h00, 8'h00, 8'h00, 1'b0, 8'h04, 8'h04, 8'h00, 8'h01, 8'hA6, 1'b0, 1'b0};
    tbl[18] = '{6'b000100, 5'b00000, 5'b00000, 1'b0, 1'b0, 3'b000, 8'h3C, 8'h00, 8'h00, 1'b0, 8'h04, 8'h04, 8'h00, 8'h3C, 8'hA6, 1'b0, 1'b0};
    tbl[19] = '{6'b100000, 5'b00000, 5'b00000, 1'b1, 1'b0, 3'b111, 8'h00, 8'h09, 8'h09, 1'b0, 8'h09, 8'h04, 8'h00, 8'h3C, 8'hA6, 1'b0, 1'b0};
    tbl[20] = '{6'b001000, 5'b00000, 5'b00000, 1'b1, 1'b1, 3'b100, 8'h00, 8'h55, 8'h3C, 1'b1, 8'h09, 8'h04, 8'h3C, 8'h3C, 8'hA6, 1'b0, 1'b0};
    tbl[21] = '{6'b001000, 5'b00000, 5'b00000, 1'b0, 1'b0, 3'b111, 8'h00, 8'hEE, 8'h00, 1'b0, 8'h09, 8'h04, 8'h00, 8'h3C, 8'hA6, 1'b0, 1'b0};
    tbl[22] = '{6'b000010, 5'b00000, 5'b00000, 1'b1, 1'b1, 3'b111, 8'h00, 8'h42, 8'h42, 1'b0, 8'h09, 8'h04, 8'h00, 8'h3C, 8'h42, 1'b0, 1'b1};

    idle();
    reset = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("rst_ac", 0, ac_out, 8'h00);
    chk("rst_zf", 0, {7'b0, zero_flag}, 8'h01);
    @(posedge clk); #1;
    chk("rst_pc", 0, pc_out, 8'h00);
    chk("rst_ir", 0, IR, 8'h00);
    chk("rst_ar", 0, mem_addr, 8'h00);
    chk("rst_be", 0, {7'b0, bus_error}, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    prev_ar = 8'h00;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      chk("bus", i, bus_out, tbl[i].e_bus);
      chk("wdata", i, mem_wdata, tbl[i].e_bus);
      chk("we", i, {7'b0, mem_we}, {7'b0, tbl[i].e_we});
      chk("addr", i, mem_addr, prev_ar);
      @(posedge clk); #1;
      chk("ar", i, mem_addr, tbl[i].e_ar);
      chk("pc", i, pc_out, tbl[i].e_pc);
      chk("dr", i, dr_out, tbl[i].e_dr);
      chk("ac", i, ac_out, tbl[i].e_ac);
      chk("ir", i, IR, tbl[i].e_ir);
      chk("zf", i, {7'b0, zero_flag}, {7'b0, tbl[i].e_zf});
      chk("be", i, {7'b0, bus_error}, {7'b0, tbl[i].e_be});
      prev_ar = tbl[i].e_ar;
    end

    // bus_error must survive idle cycles
    @(negedge clk);
    idle();
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("be_sticky", k, {7'b0, bus_error}, 8'h01);
    end

    // Build AC=0x5A, PC=0x07, then reset mid-cycle with strobes active
    @(negedge clk);
    idle(); load_AC = 1'b1; alu_result = 8'h5A;
    @(posedge clk); #1;
    @(negedge clk);
    idle(); bus_selectors = 3'b111; memory_read = 1'b1; mem_rdata = 8'h07; load_PC = 1'b1;
    @(posedge clk); #1;
    chk("pre_ac", 0, ac_out, 8'h5A);
    chk("pre_pc", 0, pc_out, 8'h07);
    @(negedge clk);
    idle(); load_AC = 1'b1; alu_result = 8'h33; inc_PC = 1'b1;
    load_DR = 1'b1; load_IR = 1'b1; bus_selectors = 3'b100; memory_write = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("mid_ac", 0, ac_out, 8'h00);
    chk("mid_pc", 0, pc_out, 8'h00);
    chk("mid_dr", 0, dr_out, 8'h00);
    chk("mid_ir", 0, IR, 8'h00);
    chk("mid_ar", 0, mem_addr, 8'h00);
    chk("mid_zf", 0, {7'b0, zero_flag}, 8'h01);
    chk("mid_be", 0, {7'b0, bus_error}, 8'h00);
    @(posedge clk); #1;
    chk("hold_ac", 0, ac_out, 8'h00);
    chk("hold_pc", 0, pc_out, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    idle();
    @(posedge clk); #1;
    chk("post_ac", 0, ac_out, 8'h00);
    chk("post_zf", 0, {7'b0, zero_flag}, 8'h01);
    chk("post_be", 0, {7'b0, bus_error}, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
